cam_capture_gray: RTL and testbench
===================================

Name: cam_capture_gray

Overview:
- Receive-side counterpart of the VGA pixel output stage. Accepts the OV7670-style camera byte stream (vsync, href, 8-bit data, RGB565 as two bytes per pixel) and converts each pixel to 8-bit grayscale.
- Produces frame-buffer write strobes and addresses, so the display path can read back the 8-bit pixel and the 4-bit averaged form.
- One instance per camera (left/right) in the stereo front end.

Parameters:
- H_ACTIVE, 640, pixels written per line.
- V_ACTIVE, 480, lines written per frame.
- ADDR_W, 19, frame-buffer address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE).
- SKIP_FRAMES, 2, frames discarded after reset while the sensor settles.

Ports:
- clk, in, 1, pixel clock; all cam_* inputs synchronous to it, sampled on rising edge.
- rst, in, 1, asynchronous active-high reset.
- cam_vsync, in, 1, frame sync; rising edge = frame start.
- cam_href, in, 1, line valid; bytes valid while high.
- cam_d, in, 8, camera data byte.
- capture_en, in, 1, enables capture of subsequent frames.
- wr_en, out, 1, frame-buffer write strobe.
- wr_addr, out, ADDR_W, write address.
- wr_data, out, 8, grayscale pixel.
- wr_data_avg, out, 4, wr_data[7:4], for the averaged display mode.
- frame_done, out, 1, one-cycle pulse at the end of a captured frame.
- line_err, out, 1, sticky per-frame framing-error flag.

Behaviour:
- Reset:
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, wr_data_avg=0, frame_done=0, line_err=0.
  - Internal: state=S_SKIP, skip count=0, byte phase=0, column/row counters=0.
- Edge detection: registered copies of cam_vsync and cam_href; rise/fall are detected from the current sample vs the registered copy.
- State machine:
  - S_SKIP: count vsync rises. When count reaches SKIP_FRAMES, go to S_WAIT; no writes in this state.
  - S_WAIT: on a vsync rise with capture_en=1, go to S_FRAME. On entry to S_FRAME: wr_addr counter=0, row=0, line_err cleared.
  - S_FRAME, next vsync rise:
    - Pulse frame_done for exactly one cycle.
    - If capture_en=1, restart S_FRAME in the same cycle (counters zeroed, line_err cleared).
    - Otherwise go to S_WAIT.
  - capture_en falling mid-frame does not abort; the current frame completes.
- Byte pairing:
  - href rise: byte phase=0, column=0.
  - Phase 0 byte is held as the high byte. The phase 1 byte completes the pixel: R5=hi[7:3], G6={hi[2:0],lo[7:5]}, B5=lo[4:0].
- Grayscale:
  - Expand to 8 bits: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - Y=(77*R8+150*G8+29*B8)>>8, computed with a 16-bit sum (max 65280 -> 255, no saturation needed).
- Latency: 2-stage pipeline. For the second byte sampled at edge N, wr_en/wr_data/wr_addr are valid in the cycle following edge N+2. wr_en is high for exactly one cycle per accepted pixel.
- Addressing: wr_addr is a running counter presented with each write and incremented after it. Row increments on href fall.
- Limits:
  - Pixels with column >= H_ACTIVE are dropped and set line_err.
  - Lines with row >= V_ACTIVE are dropped entirely (no error).
  - On a short line, the address continues from the last written value; no padding.
- Odd byte at href fall: discarded, line_err set.
- vsync rise while href is high: treated as frame start; the partial pixel is discarded.
- Reset asserted mid-frame: all state returns to reset values immediately, including a full re-skip of SKIP_FRAMES.
- wr_data_avg always equals wr_data[7:4], combinationally.

Test Plan:
1. Assert rst mid-line with href toggling -> all outputs 0 at once. After release, no wr_en until 2 vsync rises (SKIP_FRAMES=2) plus the next vsync rise with capture_en=1.
2. Color pixels, line of bytes 0xF8,0x00 / 0x07,0xE0 / 0x00,0x1F / 0xFF,0xFF / 0x00,0x00 -> wr_data 76, 149, 28, 255, 0 at addresses 0..4. wr_data_avg 4, 9, 1, 15, 0. Each write appears 2 cycles after its second byte.
3. H_ACTIVE=4, V_ACTIVE=2 bench:
   - Feed 3 lines of 4 pixels -> 8 writes at addresses 0..7; third line ignored; line_err=0.
   - Next vsync -> frame_done for one cycle and addresses restart at 0.
4. Line of 6 pixels (H_ACTIVE=4) -> 4 writes, line_err=1. Next line starts at address 4. line_err clears on the next frame start.
5. Line of 7 bytes -> 3 writes, odd byte dropped, line_err=1.
6. Deassert capture_en mid-frame -> frame completes and frame_done pulses; no wr_en on the following frame. Reassert -> capture resumes at the next vsync rise with no re-skip.

Source files
------------

// File: rtl/cam_capture_gray_if.sv
// Camera byte stream in, frame-buffer write port out, for one cam_capture_gray instance.
// The slave side is the capture block; the master side is the camera/frame-buffer environment.
interface cam_capture_gray_if #(
  parameter int ADDR_W = 19
) ();
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_d;
  logic              capture_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [3:0]        wr_data_avg;
  logic              frame_done;
  logic              line_err;

  modport master (
    output cam_vsync, cam_href, cam_d, capture_en,
    input  wr_en, wr_addr, wr_data, wr_data_avg, frame_done, line_err
  );

  modport slave (
    input  cam_vsync, cam_href, cam_d, capture_en,
    output wr_en, wr_addr, wr_data, wr_data_avg, frame_done, line_err
  );
endinterface

// File: rtl/cam_capture_gray.sv
// OV7670-style RGB565 byte stream to 8-bit grayscale frame-buffer writes.
// Skips settling frames after reset, then captures whole frames while capture_en is set.
module cam_capture_gray #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 19,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  cam_capture_gray_if.slave bus
);

  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int ROW_W  = $clog2(V_ACTIVE + 1);
  localparam int SKIP_W = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);

  localparam logic [COL_W-1:0] H_LIM = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] V_LIM = ROW_W'(V_ACTIVE);

  localparam logic [15:0] COEF_R = 16'd77;
  localparam logic [15:0] COEF_G = 16'd150;
  localparam logic [15:0] COEF_B = 16'd29;

  typedef enum logic [1:0] {
    S_SKIP,
    S_WAIT,
    S_FRAME
  } state_t;

  state_t state_q, state_d;

  logic              vsync_q, href_q;
  logic              vsync_rise, href_rise, href_fall;
  logic [SKIP_W-1:0] skip_cnt_q;
  logic              skip_done, skip_inc;
  logic              frame_start, frame_end;

  logic              phase_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic              line_err_q;
  logic              frame_done_q;

  logic              capturing, byte_first, byte_second;
  logic              row_ok, col_ok;
  logic              pix_accept, pix_overrun, odd_drop;
  logic [7:0]        byte_hi;

  logic [7:0]        pix_hi_p0, pix_lo_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              vld_p0;
  logic [15:0]       sum_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              vld_p1;
  logic              wr_en_p2;
  logic [ADDR_W-1:0] wr_addr_p2;
  logic [7:0]        wr_data_p2;

  // Weighted luma sum of the 8-bit-expanded channels; 77+150+29 = 256 keeps it within 16 bits.
  function automatic logic [15:0] gray_sum(input logic [7:0] hi, input logic [7:0] lo);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    logic [7:0] r8, g8, b8;
    r5 = hi[7:3];
    g6 = {hi[2:0], lo[7:5]};
    b5 = lo[4:0];
    r8 = {r5, r5[4:2]};
    g8 = {g6, g6[5:4]};
    b8 = {b5, b5[4:2]};
    return (COEF_R * {8'd0, r8}) + (COEF_G * {8'd0, g8}) + (COEF_B * {8'd0, b8});
  endfunction

  function automatic logic [7:0] gray_trunc(input logic [15:0] s);
    return s[15:8];
  endfunction

  assign vsync_rise = bus.cam_vsync & ~vsync_q;
  assign href_rise  = bus.cam_href & ~href_q;
  assign href_fall  = ~bus.cam_href & href_q;
  assign skip_done  = (int'(skip_cnt_q) + 1) >= SKIP_FRAMES;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_SKIP;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    skip_inc    = 1'b0;
    if (vsync_rise) begin
      case (state_q)
        S_SKIP: begin
          skip_inc = 1'b1;
          if (skip_done) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.capture_en) begin
            state_d     = S_FRAME;
            frame_start = 1'b1;
          end
        end
        S_FRAME: begin
          frame_end = 1'b1;
          if (bus.capture_en) frame_start = 1'b1;
          else                state_d     = S_WAIT;
        end
        default: state_d = S_SKIP;
      endcase
    end
  end

  // A vsync rise always wins over byte handling, which discards any half-received pixel.
  assign capturing   = (state_q == S_FRAME) && !vsync_rise;
  assign byte_first  = capturing && bus.cam_href && (href_rise || !phase_q);
  assign byte_second = capturing && bus.cam_href && !href_rise && phase_q;
  assign row_ok      = row_q < V_LIM;
  assign col_ok      = col_q < H_LIM;
  assign pix_accept  = byte_second && row_ok && col_ok;
  assign pix_overrun = byte_second && row_ok && !col_ok;
  assign odd_drop    = capturing && href_fall && phase_q && row_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      skip_cnt_q   <= '0;
      phase_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      addr_cnt_q   <= '0;
      line_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      wr_en_p2     <= 1'b0;
      wr_addr_p2   <= '0;
      wr_data_p2   <= '0;
    end else begin
      vsync_q      <= bus.cam_vsync;
      href_q       <= bus.cam_href;
      frame_done_q <= frame_end;
      if (skip_inc) skip_cnt_q <= skip_cnt_q + 1'b1;

      if (frame_start) begin
        phase_q    <= 1'b0;
        col_q      <= '0;
        row_q      <= '0;
        addr_cnt_q <= '0;
        line_err_q <= 1'b0;
      end else if (vsync_rise) begin
        phase_q <= 1'b0;
        col_q   <= '0;
      end else if (capturing) begin
        if (href_rise)   col_q   <= '0;
        if (byte_first)  phase_q <= 1'b1;
        if (byte_second) phase_q <= 1'b0;
        if (pix_accept) begin
          col_q      <= col_q + 1'b1;
          addr_cnt_q <= addr_cnt_q + 1'b1;
        end
        if (pix_overrun || odd_drop) line_err_q <= 1'b1;
        // Row advances even on dropped lines, saturating so later lines stay dropped.
        if (href_fall) begin
          phase_q <= 1'b0;
          if (row_ok) row_q <= row_q + 1'b1;
        end
      end

      // p0 -> p1 -> p2 valid chain
      vld_p0   <= pix_accept;
      vld_p1   <= vld_p0;
      wr_en_p2 <= vld_p1;
      if (vld_p1) begin
        wr_addr_p2 <= addr_p1;
        wr_data_p2 <= gray_trunc(sum_p1);
      end
    end
  end

  // Data-only stages: p0 holds the byte pair and its address, p1 the luma sum.
  always_ff @(posedge clk) begin
    if (byte_first) byte_hi <= bus.cam_d;
    if (pix_accept) begin
      pix_hi_p0 <= byte_hi;
      pix_lo_p0 <= bus.cam_d;
      addr_p0   <= addr_cnt_q;
    end
    sum_p1  <= gray_sum(pix_hi_p0, pix_lo_p0);
    addr_p1 <= addr_p0;
  end

  assign bus.wr_en       = wr_en_p2;
  assign bus.wr_addr     = wr_addr_p2;
  assign bus.wr_data     = wr_data_p2;
  assign bus.wr_data_avg = wr_data_p2[7:4];
  assign bus.frame_done  = frame_done_q;
  assign bus.line_err    = line_err_q;

endmodule

// File: tb/tb_cam_capture_gray.sv
// Directed bench for cam_capture_gray with a 4x2 active window and two skipped frames.
module tb_cam_capture_gray;
  localparam int H_ACTIVE    = 4;
  localparam int V_ACTIVE    = 2;
  localparam int ADDR_W      = 19;
  localparam int SKIP_FRAMES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc    = 0;
  int   fd_cnt = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] q_avg[$];
  int          q_wcyc[$];
  int          q_bcyc[$];

  cam_capture_gray_if #(.ADDR_W(ADDR_W)) bus ();

  cam_capture_gray #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .ADDR_W(ADDR_W),
    .SKIP_FRAMES(SKIP_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      q_addr.push_back(32'(bus.wr_addr));
      q_data.push_back(32'(bus.wr_data));
      q_avg.push_back(32'(bus.wr_data_avg));
      q_wcyc.push_back(cyc);
    end
    if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.cam_href = 1'b1;
    bus.cam_d    = d;
    tick();
  endtask

  task automatic send_pixel(input logic [15:0] px);
    send_byte(px[15:8]);
    send_byte(px[7:0]);
    q_bcyc.push_back(cyc);
  endtask

  task automatic end_line();
    bus.cam_href = 1'b0;
    bus.cam_d    = 8'h00;
    repeat (4) tick();
  endtask

  task automatic send_line(input int n, input logic [15:0] px);
    for (int i = 0; i < n; i++) send_pixel(px);
    end_line();
  endtask

  task automatic vsync_pulse();
    bus.cam_vsync = 1'b1;
    repeat (2) tick();
    bus.cam_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    chk({tag, "_wr_data_avg"}, 32'(bus.wr_data_avg), 32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_line_err"}, 32'(bus.line_err), 32'd0);
  endtask

  initial begin
    int base;
    int fd0;
    logic [31:0] exp_data[5];
    logic [31:0] exp_avg[5];
    exp_data = '{32'd76, 32'd149, 32'd28, 32'd255, 32'd0};
    exp_avg  = '{32'd4, 32'd9, 32'd1, 32'd15, 32'd0};

    bus.cam_vsync  = 1'b0;
    bus.cam_href   = 1'b0;
    bus.cam_d      = 8'h00;
    bus.capture_en = 1'b1;
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // Two settling frames: nothing written even with capture enabled.
    vsync_pulse();
    send_line(2, 16'hFFFF);
    vsync_pulse();
    send_line(2, 16'hFFFF);
    chk("skip_no_writes", 32'(q_addr.size()), 32'd0);
    vsync_pulse();
    chk("skip_no_frame_done", 32'(fd_cnt), 32'd0);

    // Color pixels across two lines, with per-pixel latency.
    q_bcyc.delete();
    base = q_addr.size();
    send_pixel(16'hF800);
    send_pixel(16'h07E0);
    send_pixel(16'h001F);
    send_pixel(16'hFFFF);
    end_line();
    send_line(1, 16'h0000);
    chk("color_count", 32'(q_addr.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("color_addr", q_addr[base+i], 32'(i));
      chk("color_data", q_data[base+i], exp_data[i]);
      chk("color_avg", q_avg[base+i], exp_avg[i]);
      chk("color_latency", 32'(q_wcyc[base+i] - q_bcyc[i]), 32'd2);
    end
    base = q_addr.size();
    send_line(4, 16'h1234);
    chk("row_limit_drop", 32'(q_addr.size() - base), 32'd0);
    chk("row_limit_no_err", 32'(bus.line_err), 32'd0);

    // Full frame: only the first V_ACTIVE lines land.
    fd0 = fd_cnt;
    vsync_pulse();
    chk("frame_done_pulse", 32'(fd_cnt - fd0), 32'd1);
    base = q_addr.size();
    send_line(4, 16'h8410);
    send_line(4, 16'h8410);
    send_line(4, 16'h8410);
    chk("frame_count", 32'(q_addr.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) chk("frame_addr", q_addr[base+i], 32'(i));
    chk("frame_no_err", 32'(bus.line_err), 32'd0);

    // Overlong line, then short continuation line.
    fd0 = fd_cnt;
    vsync_pulse();
    chk("restart_frame_done", 32'(fd_cnt - fd0), 32'd1);
    base = q_addr.size();
    send_line(6, 16'hFFFF);
    chk("long_count", 32'(q_addr.size() - base), 32'd4);
    chk("long_first_addr", q_addr[base], 32'd0);
    chk("long_last_addr", q_addr[base+3], 32'd3);
    chk("long_line_err", 32'(bus.line_err), 32'd1);
    base = q_addr.size();
    send_line(2, 16'hFFFF);
    chk("next_line_addr", q_addr[base], 32'd4);
    chk("next_line_addr2", q_addr[base+1], 32'd5);
    vsync_pulse();
    chk("err_cleared", 32'(bus.line_err), 32'd0);

    // Odd byte count at line end.
    base = q_addr.size();
    for (int i = 0; i < 3; i++) send_pixel(16'h001F);
    send_byte(8'hAA);
    end_line();
    chk("odd_count", 32'(q_addr.size() - base), 32'd3);
    chk("odd_last_addr", q_addr[base+2], 32'd2);
    chk("odd_data", q_data[base+2], 32'd28);
    chk("odd_line_err", 32'(bus.line_err), 32'd1);

    // capture_en dropped mid-frame: the frame still completes.
    bus.capture_en = 1'b0;
    base = q_addr.size();
    send_line(2, 16'hFFFF);
    chk("disable_finish_count", 32'(q_addr.size() - base), 32'd2);
    chk("disable_finish_addr", q_addr[base], 32'd3);
    fd0 = fd_cnt;
    vsync_pulse();
    chk("disable_frame_done", 32'(fd_cnt - fd0), 32'd1);
    base = q_addr.size();
    send_line(2, 16'hFFFF);
    chk("disabled_no_writes", 32'(q_addr.size() - base), 32'd0);
    bus.capture_en = 1'b1;
    fd0 = fd_cnt;
    vsync_pulse();
    chk("resume_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    base = q_addr.size();
    send_line(1, 16'hF800);
    chk("resume_count", 32'(q_addr.size() - base), 32'd1);
    chk("resume_addr", q_addr[base], 32'd0);
    chk("resume_data", q_data[base], 32'd76);

    // Reset asserted in the middle of a line with nonzero outputs.
    for (int i = 0; i < 5; i++) send_pixel(16'hFFFF);
    chk("pre_reset_addr", 32'(bus.wr_addr), 32'd4);
    chk("pre_reset_data", 32'(bus.wr_data), 32'd255);
    chk("pre_reset_err", 32'(bus.line_err), 32'd1);
    send_byte(8'h12);
    bus.cam_d = 8'h34;
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    base = q_addr.size();
    tick();
    bus.cam_href = 1'b0;
    tick();
    bus.cam_href = 1'b1;
    tick();
    rst = 1'b0;
    end_line();

    // Full re-skip after reset.
    fd0 = fd_cnt;
    vsync_pulse();
    send_line(2, 16'hFFFF);
    vsync_pulse();
    send_line(2, 16'hFFFF);
    chk("reskip_no_writes", 32'(q_addr.size() - base), 32'd0);
    vsync_pulse();
    chk("reskip_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    send_line(1, 16'h07E0);
    chk("reskip_count", 32'(q_addr.size() - base), 32'd1);
    chk("reskip_addr", q_addr[base], 32'd0);
    chk("reskip_data", q_data[base], 32'd149);
    chk("reskip_avg", q_avg[base], 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
